alu_issue_stage: RTL and testbench

//  MIPS32 issue stage between instruction fetch/register read and the combinational Alu.
//  - Decodes each instruction word into the 4-bit ALU ctrl code, selects op1/op2 from

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/alu_issue_stage_if.sv | 31 +++
 rtl/issue_skid_buffer.sv | 67 ++++++
 rtl/alu_issue_stage.sv | 104 ++++++++++
 tb/tb_alu_issue_stage.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU issue stage: ctrl codes, MIPS32 opcode/funct
// values and the issued-op payload struct.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_SLL = 4'h0,
      ALU_SRL = 4'h1,
      ALU_SRA = 4'h2,
      ALU_ADD = 4'h3,
      ALU_SUB = 4'h4,
      ALU_AND = 4'h5,
      ALU_OR  = 4'h6,
      ALU_XOR = 4'h7,
      ALU_NOR = 4'h8,
      ALU_SLT = 4'h9,
      ALU_LUI = 4'hA,
      ALU_MUL = 4'hB
   } alu_ctrl_t;

   localparam logic [5:0] OP_RTYPE    = 6'h00;
   localparam logic [5:0] OP_ADDI     = 6'h08;
   localparam logic [5:0] OP_ADDIU    = 6'h09;
   localparam logic [5:0] OP_SLTI     = 6'h0A;
   localparam logic [5:0] OP_ANDI     = 6'h0C;
   localparam logic [5:0] OP_ORI      = 6'h0D;
   localparam logic [5:0] OP_XORI     = 6'h0E;
   localparam logic [5:0] OP_LUI      = 6'h0F;
   localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_MUL  = 6'h02;

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic        illegal;
   } issue_op_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Handshake bundle of the issue stage: instruction/operand input side, Alu op output side
// and the illegal-instruction counter. slave = the stage, master = its environment.
interface alu_issue_stage_if #(
   parameter int CNT_W = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [31:0]      in_rs_data;
   logic [31:0]      in_rt_data;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       out_ctrl;
   logic [31:0]      out_op1;
   logic [31:0]      out_op2;
   logic [4:0]       out_rd;
   logic             out_illegal;
   logic [CNT_W-1:0] illegal_count;

   modport slave (
      input  in_valid, in_instr, in_rs_data, in_rt_data, out_ready,
      output in_ready, out_valid, out_ctrl, out_op1, out_op2, out_rd, out_illegal,
             illegal_count
   );

   modport master (
      output in_valid, in_instr, in_rs_data, in_rt_data, out_ready,
      input  in_ready, out_valid, out_ctrl, out_op1, out_op2, out_rd, out_illegal,
             illegal_count
   );
endinterface

// File: rtl/issue_skid_buffer.sv
// Two-entry skid buffer with registered ready; main entry drives the output, the skid
// entry absorbs one op while downstream stalls. Occupancy FSM EMPTY/ONE/FULL.
module issue_skid_buffer #(
   parameter type payload_t = logic [7:0]
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     in_valid,
   output logic     in_ready,
   input  payload_t in_data,
   output logic     out_valid,
   input  logic     out_ready,
   output payload_t out_data
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t   state_q, state_d;
   payload_t main_q, main_d;
   payload_t skid_q, skid_d;
   logic     accept, pop;

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      accept  = in_valid && (state_q != FULL);
      pop     = out_ready && (state_q != EMPTY);
      case (state_q)
         EMPTY: if (accept) begin
            main_d  = in_data;
            state_d = ONE;
         end
         ONE: begin
            if (accept && !pop) begin
               skid_d  = in_data;
               state_d = FULL;
            end else if (accept && pop) begin
               main_d  = in_data;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
         end
         default: state_d = EMPTY;
      endcase
   end

   // Outputs must read zero after reset, so the payload registers are cleared too.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end
endmodule

// File: rtl/alu_issue_stage.sv
// MIPS32 issue stage: decodes instructions into Alu ctrl/op1/op2/rd and buffers them in a
// 2-entry skid. Define ALU_ISSUE_MUL_EN to decode SPECIAL2 MUL; otherwise it is illegal.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int         CNT_W        = 16,
   parameter logic [3:0] ILLEGAL_CTRL = 4'hF
) (
   input  logic             clock,
   input  logic             reset,
   alu_issue_stage_if.slave bus
);
   issue_op_t        dec_op, out_op;
   logic             in_ready, accept;
   logic [CNT_W-1:0] count_q, count_d;

   function automatic issue_op_t decode(input logic [31:0] instr,
                                        input logic [31:0] rs,
                                        input logic [31:0] rt);
      issue_op_t   op;
      logic        legal;
      logic [3:0]  c;
      logic [31:0] a, b, sext, zext, shamt;
      logic [4:0]  d;
      sext  = {{16{instr[15]}}, instr[15:0]};
      zext  = {16'b0, instr[15:0]};
      shamt = {27'b0, instr[10:6]};
      legal = 1'b1;
      c     = ALU_ADD;
      a     = rs;
      b     = rt;
      d     = instr[15:11];
      case (instr[31:26])
         OP_RTYPE: case (instr[5:0])
            FN_SLL:           begin c = ALU_SLL; a = rt; b = shamt; end
            FN_SRL:           begin c = ALU_SRL; a = rt; b = shamt; end
            FN_SRA:           begin c = ALU_SRA; a = rt; b = shamt; end
            FN_SLLV:          begin c = ALU_SLL; a = rt; b = rs;    end
            FN_SRLV:          begin c = ALU_SRL; a = rt; b = rs;    end
            FN_SRAV:          begin c = ALU_SRA; a = rt; b = rs;    end
            FN_ADD, FN_ADDU:  c = ALU_ADD;
            FN_SUB, FN_SUBU:  c = ALU_SUB;
            FN_AND:           c = ALU_AND;
            FN_OR:            c = ALU_OR;
            FN_XOR:           c = ALU_XOR;
            FN_NOR:           c = ALU_NOR;
            FN_SLT:           c = ALU_SLT;
            default:          legal = 1'b0;
         endcase
`ifdef ALU_ISSUE_MUL_EN
         OP_SPECIAL2: begin
            if (instr[5:0] == FN_MUL) c = ALU_MUL;
            else                      legal = 1'b0;
         end
`endif
         OP_ADDI, OP_ADDIU: begin c = ALU_ADD; b = sext; d = instr[20:16]; end
         OP_SLTI:           begin c = ALU_SLT; b = sext; d = instr[20:16]; end
         OP_ANDI:           begin c = ALU_AND; b = zext; d = instr[20:16]; end
         OP_ORI:            begin c = ALU_OR;  b = zext; d = instr[20:16]; end
         OP_XORI:           begin c = ALU_XOR; b = zext; d = instr[20:16]; end
         OP_LUI:            begin c = ALU_LUI; a = zext; b = '0; d = instr[20:16]; end
         default:           legal = 1'b0;
      endcase
      if (legal) op = '{ctrl: c, op1: a, op2: b, rd: d, illegal: 1'b0};
      else       op = '{ctrl: ILLEGAL_CTRL, op1: '0, op2: '0, rd: '0, illegal: 1'b1};
      return op;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign dec_op = decode(bus.in_instr, bus.in_rs_data, bus.in_rt_data);
   assign accept = bus.in_valid && in_ready;

   always_comb begin
      count_d = count_q;
      if (accept && dec_op.illegal) count_d = sat_inc(count_q);
   end

   always_ff @(posedge clock) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   issue_skid_buffer #(.payload_t(issue_op_t)) u_skid (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (bus.in_valid),
      .in_ready  (in_ready),
      .in_data   (dec_op),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (out_op)
   );

   assign bus.in_ready      = in_ready;
   assign bus.out_ctrl      = out_op.ctrl;
   assign bus.out_op1       = out_op.op1;
   assign bus.out_op2       = out_op.op2;
   assign bus.out_rd        = out_op.rd;
   assign bus.out_illegal   = out_op.illegal;
   assign bus.illegal_count = count_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a reference decoder predicts each accepted op,
// a monitor pops predictions as the stage emits ops. A CNT_W=2 copy checks saturation.
module tb_alu_issue_stage;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   alu_issue_stage_if #(.CNT_W(16)) bus ();
   alu_issue_stage_if #(.CNT_W(2))  bus2 ();

   alu_issue_stage #(.CNT_W(16), .ILLEGAL_CTRL(4'hF)) dut (
      .clock(clock), .reset(reset), .bus(bus.slave));
   alu_issue_stage #(.CNT_W(2), .ILLEGAL_CTRL(4'hF)) dut2 (
      .clock(clock), .reset(reset), .bus(bus2.slave));

   assign bus2.in_valid   = bus.in_valid;
   assign bus2.in_instr   = bus.in_instr;
   assign bus2.in_rs_data = bus.in_rs_data;
   assign bus2.in_rt_data = bus.in_rt_data;
   assign bus2.out_ready  = bus.out_ready;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int unsigned mcount = 0;
   int unsigned mcount2 = 0;
   int          rmode = 1;  // 0 random out_ready, 1 hold low, 2 hold high

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Reference decoder straight from the instruction tables.
   function automatic exp_t model(input logic [31:0] w, input logic [31:0] rs,
                                  input logic [31:0] rt);
      exp_t e;
      logic [31:0] sh, se, ze;
      sh = {27'd0, w[10:6]};
      se = {{16{w[15]}}, w[15:0]};
      ze = {16'd0, w[15:0]};
      e.ctrl = 4'hF; e.op1 = rs; e.op2 = rt; e.rd = w[15:11]; e.ill = 1'b0;
      if (w[31:26] == 6'h00) begin
         case (w[5:0])
            6'h00: begin e.ctrl = 4'h0; e.op1 = rt; e.op2 = sh; end
            6'h02: begin e.ctrl = 4'h1; e.op1 = rt; e.op2 = sh; end
            6'h03: begin e.ctrl = 4'h2; e.op1 = rt; e.op2 = sh; end
            6'h04: begin e.ctrl = 4'h0; e.op1 = rt; e.op2 = rs; end
            6'h06: begin e.ctrl = 4'h1; e.op1 = rt; e.op2 = rs; end
            6'h07: begin e.ctrl = 4'h2; e.op1 = rt; e.op2 = rs; end
            6'h20, 6'h21: e.ctrl = 4'h3;
            6'h22, 6'h23: e.ctrl = 4'h4;
            6'h24: e.ctrl = 4'h5;
            6'h25: e.ctrl = 4'h6;
            6'h26: e.ctrl = 4'h7;
            6'h27: e.ctrl = 4'h8;
            6'h2A: e.ctrl = 4'h9;
            default: e.ill = 1'b1;
         endcase
      end else begin
         e.rd = w[20:16];
         case (w[31:26])
            6'h08, 6'h09: begin e.ctrl = 4'h3; e.op2 = se; end
            6'h0A: begin e.ctrl = 4'h9; e.op2 = se; end
            6'h0C: begin e.ctrl = 4'h5; e.op2 = ze; end
            6'h0D: begin e.ctrl = 4'h6; e.op2 = ze; end
            6'h0E: begin e.ctrl = 4'h7; e.op2 = ze; end
            6'h0F: begin e.ctrl = 4'hA; e.op1 = ze; e.op2 = 32'd0; end
`ifdef ALU_ISSUE_MUL_EN
            6'h1C: begin
               if (w[5:0] == 6'h02) begin e.ctrl = 4'hB; e.rd = w[15:11]; end
               else e.ill = 1'b1;
            end
`endif
            default: e.ill = 1'b1;
         endcase
      end
      if (e.ill) begin
         e.ctrl = 4'hF; e.op1 = 32'd0; e.op2 = 32'd0; e.rd = 5'd0;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [5:0]  rfn [0:12];
      logic [5:0]  ops [0:7];
      int k;
      rfn = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
              6'h24, 6'h27, 6'h2A};
      ops = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h25};
      w = $urandom();
      k = $urandom_range(0, 9);
      if (k == 0) w[31:26] = 6'h00;
      else if (k <= 3) begin w[31:26] = 6'h00; w[5:0] = rfn[$urandom_range(0, 12)]; end
      else if (k <= 6) w[31:26] = ops[$urandom_range(0, 6)];
      else if (k == 7) begin
         w[31:26] = 6'h1C;
         if ($urandom_range(0, 1) == 1) w[5:0] = 6'h02;
      end
      if (k == 3) w[5:0] = 6'h25;
      return w;
   endfunction

   task automatic push_expect(input logic [31:0] w, input logic [31:0] rs,
                              input logic [31:0] rt);
      exp_t e;
      e = model(w, rs, rt);
      sb.push_back(e);
      if (e.ill) begin
         if (mcount < 32'h0000FFFF) mcount++;
         if (mcount2 < 3) mcount2++;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      bus.in_valid = 1'b1; bus.in_instr = w; bus.in_rs_data = rs; bus.in_rt_data = rt;
      while (!done) begin
         @(negedge clock); #1;
         if (bus.in_ready) begin
            push_expect(w, rs, rt);
            done = 1'b1;
         end
         @(posedge clock); #1;
         n++;
         if (!done && n > 100) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got no accept in 100 cycles, expected in_ready");
            done = 1'b1;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      rmode = 2;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      chk("drain_queue_left", sb.size(), 0);
      @(posedge clock); #1;
   endtask

   task automatic do_reset(input int cycles);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      sb.delete();
      mcount = 0;
      mcount2 = 0;
      repeat (cycles) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock); #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_ctrl", bus.out_ctrl, 0);
      chk("rst_op1", bus.out_op1, 0);
      chk("rst_op2", bus.out_op2, 0);
      chk("rst_rd", bus.out_rd, 0);
      chk("rst_illegal", bus.out_illegal, 0);
      chk("rst_count", bus.illegal_count, 0);
      @(posedge clock); #1;
   endtask

   // out_ready driver
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clock); #1;
         case (rmode)
            0:       bus.out_ready = ($urandom_range(0, 3) != 0);
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'b1;
         endcase
      end
   end

   // Monitor / scoreboard checker
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
               tests++;
               if (sb.size() == 0) begin
                  fails++;
                  $display("FAIL out_unexpected: got ctrl=%h rd=%0d with nothing pending, expected no output",
                           bus.out_ctrl, bus.out_rd);
               end else begin
                  e = sb.pop_front();
                  if (bus.out_ctrl !== e.ctrl || bus.out_op1 !== e.op1 || bus.out_op2 !== e.op2 ||
                      bus.out_rd !== e.rd || bus.out_illegal !== e.ill) begin
                     fails++;
                     $display("FAIL out_op: got ctrl=%h op1=%h op2=%h rd=%0d ill=%b, expected ctrl=%h op1=%h op2=%h rd=%0d ill=%b",
                              bus.out_ctrl, bus.out_op1, bus.out_op2, bus.out_rd, bus.out_illegal,
                              e.ctrl, e.op1, e.op2, e.rd, e.ill);
                  end
               end
            end
            chk("illegal_count", 32'(bus.illegal_count), mcount);
            chk("illegal_count_w2", 32'(bus2.illegal_count), mcount2);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      logic [31:0] c0;
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_rs_data = '0; bus.in_rt_data = '0;
      @(posedge clock); #1;
      do_reset(3);

      // addiu, sll, lui
      rmode = 2;
      send(32'h2422FFFF, 32'd5, 32'd99);
      send(32'h00021900, 32'h0BAD0BAD, 32'h1);
      send(32'h3C051234, $urandom(), $urandom());
      drain();

      // stall with three back-to-back ops: skid fills after two
      rmode = 1;
      @(posedge clock); #1;
      send(32'h00221820, 32'd10, 32'd20);
      send(32'h00221822, 32'd30, 32'd7);
      bus.in_valid = 1'b1; bus.in_instr = 32'h00221825;
      bus.in_rs_data = 32'hF0F0_0000; bus.in_rt_data = 32'h0000_0F0F;
      @(negedge clock); #1;
      chk("in_ready_full", bus.in_ready, 0);
      rmode = 2;
      send(32'h00221825, 32'hF0F0_0000, 32'h0000_0F0F);
      drain();

      // mid-stream reset discards buffered ops
      rmode = 1;
      @(posedge clock); #1;
      send(32'h2422FFFF, 32'd1, 32'd2);
      send(32'h3C051234, 32'd3, 32'd4);
      do_reset(3);

      // illegal instructions and counter saturation at CNT_W=2
      rmode = 2;
      repeat (3) send(32'hFC000000, $urandom(), $urandom());
      drain();
      chk("count_after_3", bus.illegal_count, 3);
      repeat (2) send(32'hFC000000, $urandom(), $urandom());
      drain();
      chk("count_after_5", bus.illegal_count, 5);
      chk("count_w2_sat", bus2.illegal_count, 3);

      // SPECIAL2 MUL
      c0 = 32'(bus.illegal_count);
      send(32'h70222002, 32'd6, 32'd7);
      drain();
`ifdef ALU_ISSUE_MUL_EN
      chk("mul_count", bus.illegal_count, c0);
`else
      chk("mul_count", bus.illegal_count, c0 + 1);
`endif

      // randomized traffic with random downstream backpressure
      rmode = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clock); #1;
         end
         send(rand_instr(), ($urandom_range(0, 1) == 1) ? $urandom() : $urandom_range(0, 40),
              $urandom());
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
